// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and register-index type.
// Reused by the register file and the instruction decoder.
package mips_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam reg_idx_t REG_ZERO = reg_idx_t'(0);

endpackage

// File: rtl/mips_register_file_if.sv
// Register-file access bus: one write port (rd/din/writeEnable), two read ports.
// Decode/writeback drive through master; the register file sits on slave.
interface mips_register_file_if;
  import mips_pkg::*;

  word_t    din;
  logic     writeEnable;
  reg_idx_t rs;
  reg_idx_t rt;
  reg_idx_t rd;
  word_t    regA;
  word_t    regB;

  modport master (
    output din, writeEnable, rs, rt, rd,
    input  regA, regB
  );

  modport slave (
    input  din, writeEnable, rs, rt, rd,
    output regA, regB
  );

endinterface

// File: rtl/regfile_read_port.sv
// One read port: index -> data mux with register-0 masking and optional write forwarding.
// Latency: combinational. Backpressure: none.
module regfile_read_port
  import mips_pkg::*;
(
  input  logic                               rst,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
  input  reg_idx_t                           idx,
  input  logic                               we,
  input  reg_idx_t                           wr_idx,
  input  word_t                              wr_dat,
  output word_t                              dat
);

`ifdef REGFILE_WRITE_BYPASS_EN
  // Reset must dominate forwarding so the port reads 0 while rst is high.
  always_comb begin
    dat = regs[idx];
    if (idx == REG_ZERO) begin
      dat = '0;
    end else if (!rst && we && (wr_idx == idx)) begin
      dat = wr_dat;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rst, we, wr_idx, wr_dat};

  always_comb begin
    dat = regs[idx];
    if (idx == REG_ZERO) begin
      dat = '0;
    end
  end
`endif

endmodule

// File: rtl/mips_register_file.sv
// 32x32 MIPS register file, r0 hardwired to zero; REGFILE_WRITE_BYPASS_EN adds write-through forwarding.
// Latency: reads combinational, writes one rising edge. Backpressure: none, always accepts.
module mips_register_file
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  mips_register_file_if.slave  bus
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  // Entry 0 is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (bus.writeEnable && (bus.rd != REG_ZERO)) begin
      regs[bus.rd] <= bus.din;
    end
  end

  regfile_read_port u_port_a (
    .rst    (rst),
    .regs   (regs),
    .idx    (bus.rs),
    .we     (bus.writeEnable),
    .wr_idx (bus.rd),
    .wr_dat (bus.din),
    .dat    (bus.regA)
  );

  regfile_read_port u_port_b (
    .rst    (rst),
    .regs   (regs),
    .idx    (bus.rt),
    .we     (bus.writeEnable),
    .wr_idx (bus.rd),
    .wr_dat (bus.din),
    .dat    (bus.regB)
  );

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: reset, writes, r0, async reset, read-during-write.
module tb_mips_register_file;
  import mips_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  word_t model [NUM_REGS];

  mips_register_file_if bus ();

  mips_register_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Present a write mid-cycle, let one rising edge take it, then drop writeEnable.
  task automatic wr(input reg_idx_t a, input word_t d);
    @(negedge clk);
    bus.rd          = a;
    bus.din         = d;
    bus.writeEnable = 1'b1;
    @(posedge clk);
    #1;
    bus.writeEnable = 1'b0;
    if (a != REG_ZERO) model[a] = d;
  endtask

  task automatic rd2(input reg_idx_t a, input reg_idx_t b);
    bus.rs = a;
    bus.rt = b;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    rst             = 1'b1;
    bus.writeEnable = 1'b0;
    bus.din         = '0;
    bus.rd          = '0;
    bus.rs          = 5'd10;
    bus.rt          = 5'd11;
    #1;
    check("reset_regA_no_edge", bus.regA, 32'd0);
    check("reset_regB_no_edge", bus.regB, 32'd0);

    // Write attempted while reset is held must not land.
    bus.writeEnable = 1'b1;
    bus.rd          = 5'd5;
    bus.din         = 32'd55;
    @(posedge clk);
    #1;
    rd2(5'd5, 5'd5);
    check("write_blocked_in_reset", bus.regA, 32'd0);
    @(negedge clk);
    bus.writeEnable = 1'b0;
    rst             = 1'b0;

    bus.rs = 5'd10;
    bus.rt = 5'd11;
    wr(5'd1, 32'd1234);
    wr(5'd2, 32'd6666);
    wr(5'd10, 32'd7777);
    rd2(5'd10, 5'd11);
    check("regA_after_r10_write", bus.regA, 32'd7777);
    check("regB_before_r11_write", bus.regB, 32'd0);
    wr(5'd11, 32'd2021);
    rd2(5'd10, 5'd11);
    check("regB_after_r11_write", bus.regB, 32'd2021);

    // Write disabled: din/rd changes must not disturb anything.
    @(negedge clk);
    bus.writeEnable = 1'b0;
    bus.din         = 32'd2022;
    bus.rd          = 5'd7;
    @(posedge clk);
    #1;
    rd2(5'd1, 5'd2);
    check("readback_r1", bus.regA, 32'd1234);
    check("readback_r2", bus.regB, 32'd6666);
    rd2(5'd10, 5'd11);
    check("readback_r10", bus.regA, 32'd7777);
    check("readback_r11", bus.regB, 32'd2021);
    for (int i = 0; i < NUM_REGS; i++) begin
      rd2(reg_idx_t'(i), reg_idx_t'(NUM_REGS - 1 - i));
      check($sformatf("sweep_A_r%0d", i), bus.regA, model[i]);
      check($sformatf("sweep_B_r%0d", NUM_REGS - 1 - i), bus.regB, model[NUM_REGS - 1 - i]);
    end

    wr(5'd0, 32'hDEADBEEF);
    rd2(5'd0, 5'd0);
    check("r0_regA", bus.regA, 32'd0);
    check("r0_regB", bus.regB, 32'd0);
    rd2(5'd1, 5'd1);
    check("rs_eq_rt_A", bus.regA, 32'd1234);
    check("rs_eq_rt_B", bus.regB, 32'd1234);

    // Asynchronous reset between edges.
    @(negedge clk);
    rst = 1'b1;
    rd2(5'd10, 5'd11);
    check("async_rst_r10", bus.regA, 32'd0);
    check("async_rst_r11", bus.regB, 32'd0);
    rd2(5'd1, 5'd2);
    check("async_rst_r1", bus.regA, 32'd0);
    check("async_rst_r2", bus.regB, 32'd0);
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    wr(5'd3, 32'd5);
    rd2(5'd3, 5'd10);
    check("post_rst_r3", bus.regA, 32'd5);
    check("post_rst_r10", bus.regB, 32'd0);

    // Read-during-write on the same index.
    wr(5'd4, 32'd7);
    @(negedge clk);
    bus.rd          = 5'd4;
    bus.din         = 32'd99;
    bus.writeEnable = 1'b1;
    rd2(5'd4, 5'd4);
`ifdef REGFILE_WRITE_BYPASS_EN
    check("rdw_before_edge_A", bus.regA, 32'd99);
    check("rdw_before_edge_B", bus.regB, 32'd99);
`else
    check("rdw_before_edge_A", bus.regA, 32'd7);
    check("rdw_before_edge_B", bus.regB, 32'd7);
`endif
    @(posedge clk);
    #1;
    bus.writeEnable = 1'b0;
    rd2(5'd4, 5'd3);
    check("rdw_after_edge", bus.regA, 32'd99);
    check("rdw_other_reg", bus.regB, 32'd5);

    // r0 stays zero even while a write to it is pending.
    @(negedge clk);
    bus.rd          = 5'd0;
    bus.din         = 32'd123;
    bus.writeEnable = 1'b1;
    rd2(5'd0, 5'd4);
    check("r0_pending_write", bus.regA, 32'd0);
    check("r4_unaffected", bus.regB, 32'd99);
    @(posedge clk);
    #1;
    bus.writeEnable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
